data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//   Shares the single-port 128x8 data RAM between the CPU core's execute stage and a
//   host/debug port (loader, monitor). One access per cycle: CPU has default priority,
//   host is protected by a starvation counter, and host may lock the RAM for bursts.
//   Sits between the core and single_port_ram_128x8; read data is steered back by owner.
// PARAMETERS
//   ADDR_W         7   RAM address width
//   DATA_W         8   RAM data width
//   HOST_MAX_WAIT  4   contended cycles host may lose before it wins; 0 = host fixed priority
// PORTS
//   clk         in   1       clock, all state on posedge
//   rst         in   1       reset, asynchronous, active-high
//   cpu_req     in   1       CPU access request; held until cpu_gnt
//   cpu_we      in   1       1 = write, 0 = read
//   cpu_addr    in   ADDR_W  CPU address
//   cpu_wdata   in   DATA_W  CPU write data
//   cpu_gnt     out  1       CPU access accepted this cycle
//   cpu_rvalid  out  1       CPU read data valid
//   cpu_rdata   out  DATA_W  CPU read data
//   host_req    in   1       host access request; held until host_gnt
//   host_we     in   1       1 = write, 0 = read
//   host_lock   in   1       keep RAM owned by host after current grant
//   host_addr   in   ADDR_W  host address
//   host_wdata  in   DATA_W  host write data
//   host_gnt    out  1       host access accepted this cycle
//   host_rvalid out  1       host read data valid
//   host_rdata  out  DATA_W  host read data
//   ram_addr    out  ADDR_W  to RAM addr
//   ram_wdata   out  DATA_W  to RAM data
//   ram_en      out  1       to RAM write enable
//   ram_q       in   DATA_W  from RAM q, valid the cycle after address presented
// BEHAVIOUR
//   Reset: state=IDLE, wait_cnt=0, owner/rd-pending regs=0, *_rdata=0, *_rvalid=0;
//     while rst=1 cpu_gnt, host_gnt, ram_en forced 0. Mid-transaction reset drops the
//     access; a pending read returns no rvalid.
//   FSM (registered): IDLE, CPU, HOST, HOST_LOCK; records last owner.
//     Grant is combinational from req, state, wait_cnt; at most one gnt per cycle.
//     HOST_LOCK: only host granted; cpu_gnt=0 even if host_req=0. Leave to IDLE when
//       host_lock=0 at a clock edge with no host grant; else stay.
//     Otherwise: only one req -> grant it. Both req -> host if wait_cnt==HOST_MAX_WAIT,
//       else CPU. Host grant with host_lock=1 -> next state HOST_LOCK.
//     Next state = CPU/HOST on respective grant, IDLE on no grant.
//   wait_cnt: +1 per cycle host_req=1 & host_gnt=0, saturates at HOST_MAX_WAIT,
//     cleared on host_gnt.
//   Datapath: ram_addr/ram_wdata mux granted requester (CPU when none);
//     ram_en = gnt & we of winner.
//   Read latency 1: granted read at cycle T -> <owner>_rvalid=1 at T+1 for one cycle,
//     <owner>_rdata=ram_q at T+1, then held until next read for that owner.
//   Back-to-back reads/writes every cycle allowed; write at T then read same addr
//     at T+1 returns new data at T+2.
//   Requesters must hold req/we/addr/wdata stable until gnt; request may drop
//     (no grant, no side effect).
// TESTING
//   1 CPU write 0x20<-0xA5, then read 0x20 -> cpu_gnt each cycle, ram_en=1 then 0,
//     cpu_rvalid next cycle, cpu_rdata=0xA5.
//   2 Both req continuously, HOST_MAX_WAIT=4 -> CPU wins 4 cycles, host 5th,
//     wait_cnt back to 0, repeats.
//   3 host_lock=1, host writes 0x10..0x13 with host_req gaps, cpu_req=1 throughout
//     -> cpu_gnt=0 until lock drops, then CPU granted.
//   4 Interleaved reads CPU@0x05(=0x11), host@0x06(=0x22) -> each rvalid only on
//     own port, rdata 0x11/0x22.
//   5 Assert rst async mid-read -> gnts/ram_en 0 immediately, no rvalid,
//     state IDLE, rdata=0.
//   6 HOST_MAX_WAIT=0, both req -> host always granted; CPU granted only when
//     host_req=0.

Source files
------------

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Purpose  : Shares one single-port data RAM between the CPU execute stage and
//            a host/debug port. One access per cycle. The CPU has default
//            priority. The host is protected by a starvation counter and may
//            lock the RAM for bursts. Read data returns to its owner one
//            cycle after the grant.
// Ports    : clk, rst                        - clock, async active-high reset
//            cpu_req/we/addr/wdata -> cpu_gnt - CPU request, accepted this cycle
//            cpu_rvalid/cpu_rdata            - CPU read return
//            host_req/we/lock/addr/wdata -> host_gnt - host request
//            host_rvalid/host_rdata          - host read return
//            ram_addr/ram_wdata/ram_en, ram_q - RAM side (ram_en = write enable)
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_arbiter #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 8,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_q
);

  // Counter must hold HOST_MAX_WAIT; keep at least one bit when it is 0.
  localparam int c_WAIT_W = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CPU       = 2'd1,
    S_HOST      = 2'd2,
    S_HOST_LOCK = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_cpu_rd_pend;
  logic                r_host_rd_pend;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                w_cpu_gnt;
  logic                w_host_gnt;

  // Grant decision. Reset forces both grants low so nothing reaches the RAM
  // while reset is asserted, even mid-cycle.
  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (!rst) begin
      if (r_state == S_HOST_LOCK) begin
        w_host_gnt = host_req;
      end else if (cpu_req && host_req) begin
        // With HOST_MAX_WAIT = 0 the counter sits at 0 == max, so the host
        // always wins contention.
        if (r_wait_cnt == c_WAIT_MAX) begin
          w_host_gnt = 1'b1;
        end else begin
          w_cpu_gnt = 1'b1;
        end
      end else begin
        w_cpu_gnt  = cpu_req;
        w_host_gnt = host_req;
      end
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    if (r_state == S_HOST_LOCK) begin
      // Lock is released only on an edge where the host is not being served.
      w_next_state = (!w_host_gnt && !host_lock) ? S_IDLE : S_HOST_LOCK;
    end else if (w_host_gnt) begin
      w_next_state = host_lock ? S_HOST_LOCK : S_HOST;
    end else if (w_cpu_gnt) begin
      w_next_state = S_CPU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_cpu_rd_pend  <= 1'b0;
      r_host_rd_pend <= 1'b0;
      r_cpu_rdata    <= '0;
      r_host_rdata   <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_host_gnt) begin
        r_wait_cnt <= '0;
      end else if (host_req && (r_wait_cnt != c_WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      r_cpu_rd_pend  <= w_cpu_gnt & ~cpu_we;
      r_host_rd_pend <= w_host_gnt & ~host_we;

      // Capture the returned word so it stays visible until the next read.
      if (r_cpu_rd_pend) begin
        r_cpu_rdata <= ram_q;
      end
      if (r_host_rd_pend) begin
        r_host_rdata <= ram_q;
      end
    end
  end

  assign cpu_gnt  = w_cpu_gnt;
  assign host_gnt = w_host_gnt;

  // CPU drives the RAM bus whenever the host is not granted.
  assign ram_addr  = w_host_gnt ? host_addr  : cpu_addr;
  assign ram_wdata = w_host_gnt ? host_wdata : cpu_wdata;
  assign ram_en    = (w_host_gnt & host_we) | (w_cpu_gnt & cpu_we);

  // RAM output is valid in the return cycle; afterwards the held copy is used.
  assign cpu_rvalid  = r_cpu_rd_pend;
  assign cpu_rdata   = r_cpu_rd_pend  ? ram_q : r_cpu_rdata;
  assign host_rvalid = r_host_rd_pend;
  assign host_rdata  = r_host_rd_pend ? ram_q : r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_arbiter
// Purpose  : Directed self-checking bench for data_ram_arbiter with a
//            behavioural 128x8 single-port RAM. A second instance uses
//            HOST_MAX_WAIT = 0 for the fixed host priority case.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [6:0] cpu_addr, host_addr;
  logic [7:0] cpu_wdata, host_wdata;
  logic       cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, ram_en;
  logic [7:0] cpu_rdata, host_rdata, ram_wdata, ram_q;
  logic [6:0] ram_addr;

  logic       d0_cpu_req, d0_host_req;
  logic [6:0] d0_addr;
  logic [7:0] d0_wdata, d0_ram_q;
  logic       d0_cpu_gnt, d0_host_gnt, d0_cpu_rvalid, d0_host_rvalid, d0_ram_en;
  logic [7:0] d0_cpu_rdata, d0_host_rdata, d0_ram_wdata;
  logic [6:0] d0_ram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [128];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  data_ram_arbiter #(.ADDR_W(7), .DATA_W(8), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en), .ram_q(ram_q)
  );

  data_ram_arbiter #(.ADDR_W(7), .DATA_W(8), .HOST_MAX_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(d0_cpu_req), .cpu_we(1'b0), .cpu_addr(d0_addr), .cpu_wdata(d0_wdata),
    .cpu_gnt(d0_cpu_gnt), .cpu_rvalid(d0_cpu_rvalid), .cpu_rdata(d0_cpu_rdata),
    .host_req(d0_host_req), .host_we(1'b0), .host_lock(1'b0),
    .host_addr(d0_addr), .host_wdata(d0_wdata),
    .host_gnt(d0_host_gnt), .host_rvalid(d0_host_rvalid), .host_rdata(d0_host_rdata),
    .ram_addr(d0_ram_addr), .ram_wdata(d0_ram_wdata), .ram_en(d0_ram_en), .ram_q(d0_ram_q)
  );

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h00; cpu_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b1; host_lock = 1'b0; host_addr = 7'h00; host_wdata = 8'h00;
    d0_cpu_req = 1'b0; d0_host_req = 1'b0; d0_addr = 7'h00; d0_wdata = 8'h00; d0_ram_q = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_gnt: got %b expected 0", cpu_gnt); end
    n_checks++; if (host_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_host_gnt: got %b expected 0", host_gnt); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rvalid: got %b expected 0", cpu_rvalid); end
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_host_rvalid: got %b expected 0", host_rvalid); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h expected 00", cpu_rdata); end
    n_checks++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_host_rdata: got %h expected 00", host_rdata); end
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_cpu_rw();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h20; cpu_wdata = 8'hA5; #1;
    n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rw_wr_gnt: got %b expected 1", cpu_gnt); end
    n_checks++; if (ram_en !== 1'b1) begin n_fail++; $display("FAIL rw_wr_en: got %b expected 1", ram_en); end
    n_checks++; if (ram_addr !== 7'h20) begin n_fail++; $display("FAIL rw_wr_addr: got %h expected 20", ram_addr); end
    n_checks++; if (ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL rw_wr_data: got %h expected a5", ram_wdata); end
    @(negedge clk);
    cpu_we = 1'b0; #1;
    n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rw_rd_gnt: got %b expected 1", cpu_gnt); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rw_rd_en: got %b expected 0", ram_en); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_no_rvalid_after_wr: got %b expected 0", cpu_rvalid); end
    @(negedge clk);
    cpu_req = 1'b0; #1;
    n_checks++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL rw_rvalid: got %b expected 1", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL rw_rdata: got %h expected a5", cpu_rdata); end
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_host_rvalid: got %b expected 0", host_rvalid); end
    @(negedge clk); #1;
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_rvalid_pulse: got %b expected 0", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL rw_rdata_hold: got %h expected a5", cpu_rdata); end
  endtask

  task automatic test_starvation();
    logic exp_h;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h00;
      host_req = 1'b1; host_we = 1'b0; host_lock = 1'b0; host_addr = 7'h01; #1;
      exp_h = ((i % 5) == 4);
      n_checks++; if (host_gnt !== exp_h) begin n_fail++; $display("FAIL starve_host_gnt[%0d]: got %b expected %b", i, host_gnt, exp_h); end
      n_checks++; if (cpu_gnt !== !exp_h) begin n_fail++; $display("FAIL starve_cpu_gnt[%0d]: got %b expected %b", i, cpu_gnt, !exp_h); end
      n_checks++; if (ram_addr !== {6'd0, exp_h}) begin n_fail++; $display("FAIL starve_addr[%0d]: got %h expected %h", i, ram_addr, {6'd0, exp_h}); end
    end
  endtask

  task automatic test_host_lock();
    bit hreq [12] = '{1,1,1,1,1,0,1,0,1,1,0,0};
    bit lck  [12] = '{1,1,1,1,1,1,1,1,1,1,0,0};
    bit expc [12] = '{1,1,1,1,0,0,0,0,0,0,0,1};
    bit exph [12] = '{0,0,0,0,1,0,1,0,1,1,0,0};
    int idx = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h30;
      host_req = hreq[i]; host_we = 1'b1; host_lock = lck[i];
      host_addr = 7'h10 + 7'(idx); host_wdata = 8'h50 + 8'(idx); #1;
      n_checks++; if (cpu_gnt !== expc[i]) begin n_fail++; $display("FAIL lock_cpu_gnt[%0d]: got %b expected %b", i, cpu_gnt, expc[i]); end
      n_checks++; if (host_gnt !== exph[i]) begin n_fail++; $display("FAIL lock_host_gnt[%0d]: got %b expected %b", i, host_gnt, exph[i]); end
      n_checks++; if (ram_en !== exph[i]) begin n_fail++; $display("FAIL lock_ram_en[%0d]: got %b expected %b", i, ram_en, exph[i]); end
      if (exph[i]) idx++;
    end
    @(negedge clk);
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_interleave();
    host_lock = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h05; cpu_wdata = 8'h11; host_req = 1'b0;
    @(negedge clk);
    cpu_addr = 7'h06; cpu_wdata = 8'h22;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 7'h05; #1;
    n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL il_cpu_gnt: got %b expected 1", cpu_gnt); end
    @(negedge clk);
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 7'h06; #1;
    n_checks++; if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL il_host_gnt: got %b expected 1", host_gnt); end
    n_checks++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL il_cpu_rvalid: got %b expected 1", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 8'h11) begin n_fail++; $display("FAIL il_cpu_rdata: got %h expected 11", cpu_rdata); end
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL il_host_rvalid_early: got %b expected 0", host_rvalid); end
    @(negedge clk);
    host_addr = 7'h12; #1;
    n_checks++; if (host_rvalid !== 1'b1) begin n_fail++; $display("FAIL il_host_rvalid: got %b expected 1", host_rvalid); end
    n_checks++; if (host_rdata !== 8'h22) begin n_fail++; $display("FAIL il_host_rdata: got %h expected 22", host_rdata); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL il_cpu_rvalid_steer: got %b expected 0", cpu_rvalid); end
    @(negedge clk);
    host_req = 1'b0; #1;
    n_checks++; if (host_rdata !== 8'h52) begin n_fail++; $display("FAIL il_lock_data: got %h expected 52", host_rdata); end
    @(negedge clk); #1;
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL il_host_rvalid_pulse: got %b expected 0", host_rvalid); end
    n_checks++; if (host_rdata !== 8'h52) begin n_fail++; $display("FAIL il_host_rdata_hold: got %h expected 52", host_rdata); end
    n_checks++; if (cpu_rdata !== 8'h11) begin n_fail++; $display("FAIL il_cpu_rdata_hold: got %h expected 11", cpu_rdata); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h05;
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h7F; host_wdata = 8'hEE; #1;
    n_checks++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL arst_pre_gnt: got %b expected 1", cpu_gnt); end
    #2 rst = 1'b1; #1;
    n_checks++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL arst_cpu_gnt: got %b expected 0", cpu_gnt); end
    n_checks++; if (host_gnt !== 1'b0) begin n_fail++; $display("FAIL arst_host_gnt: got %b expected 0", host_gnt); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL arst_ram_en: got %b expected 0", ram_en); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL arst_cpu_rdata: got %h expected 00", cpu_rdata); end
    n_checks++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL arst_host_rdata: got %h expected 00", host_rdata); end
    @(negedge clk); #1;
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL arst_rvalid_in_rst: got %b expected 0", cpu_rvalid); end
    rst = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL arst_rvalid_after: got %b expected 0", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL arst_rdata_after: got %h expected 00", cpu_rdata); end
  endtask

  task automatic test_fixed_priority();
    bit creq [6] = '{1,1,1,1,0,1};
    bit hreq [6] = '{1,1,1,0,1,1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d0_cpu_req = creq[i]; d0_host_req = hreq[i]; #1;
      n_checks++; if (d0_host_gnt !== hreq[i]) begin n_fail++; $display("FAIL fixed_host_gnt[%0d]: got %b expected %b", i, d0_host_gnt, hreq[i]); end
      n_checks++; if (d0_cpu_gnt !== (creq[i] && !hreq[i])) begin n_fail++; $display("FAIL fixed_cpu_gnt[%0d]: got %b expected %b", i, d0_cpu_gnt, creq[i] && !hreq[i]); end
    end
    @(negedge clk);
    d0_cpu_req = 1'b0; d0_host_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_starvation();
    test_host_lock();
    test_interleave();
    test_async_reset();
    test_fixed_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
